// File: rtl/peak_readout_streamer_pkg.sv
// Shared widths, frame type and FSM encoding for the peak readout streamer.
// Kept consistent with the histogram builder's header (NP, PIXEL_NUM, PIX_W).
package peak_readout_streamer_pkg;

  localparam int NP        = 16;
  localparam int PIXEL_NUM = 8;
  localparam int PIX_W     = 3;
  localparam int LAST_PIX  = PIXEL_NUM - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef logic [NP*PIXEL_NUM-1:0] frame_t;

  function automatic logic [NP-1:0] pick_pixel(input frame_t f, input logic [PIX_W-1:0] idx);
    return f[idx*NP +: NP];
  endfunction

endpackage

// File: rtl/peak_readout_streamer_if.sv
// Valid/ready beat stream from the peak readout streamer to the depth/readout path.
interface peak_readout_streamer_if;
  import peak_readout_streamer_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [NP-1:0]    out_data;
  logic [PIX_W-1:0] out_pixel;
  logic             out_last;

  modport master (output out_valid, out_data, out_pixel, out_last, input  out_ready);
  modport slave  (input  out_valid, out_data, out_pixel, out_last, output out_ready);

endinterface

// File: rtl/peak_readout_streamer_depth_scaler.sv
// Combinational depth scaler: (peak * SCALE) >> SCALE_SHIFT, saturated to NP bits.
module peak_depth_scaler
  import peak_readout_streamer_pkg::*;
#(
  parameter logic [15:0] SCALE       = 16'd150,
  parameter int          SCALE_SHIFT = 4
) (
  input  logic [NP-1:0] peak_i,
  output logic [NP-1:0] depth_o
);

  logic [NP+15:0] prod;
  logic [NP+15:0] shifted;

  always_comb begin
    prod    = {16'b0, peak_i} * {{NP{1'b0}}, SCALE};
    shifted = prod >> SCALE_SHIFT;
    depth_o = (|shifted[NP+15:NP]) ? '1 : shifted[NP-1:0];
  end

endmodule

// File: rtl/peak_readout_streamer.sv
// Snapshots finished histogram frames and streams one peak per beat, with one
// pending frame of slack. Optional depth scaling under PEAK_DEPTH_SCALE_EN.
module peak_readout_streamer
  import peak_readout_streamer_pkg::*;
#(
  parameter int FID_W = 8
`ifdef PEAK_DEPTH_SCALE_EN
  ,
  parameter logic [15:0] SCALE       = 16'd150,
  parameter int          SCALE_SHIFT = 4
`endif
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    peak_valid,
  input  frame_t                  peak_data,
  input  logic                    overrun_clr,
  peak_readout_streamer_if.master out_if,
  output logic [FID_W-1:0]        frame_id,
  output logic                    overrun,
  output logic                    busy
);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  frame_t           shadow_q, shadow_d;
  frame_t           pending_q, pending_d;
  logic             pending_vld_q, pending_vld_d;
  logic [FID_W-1:0] frame_id_q, frame_id_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [NP-1:0]    out_data_q, out_data_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_last_q, out_last_d;

  logic             xfer;
  logic             last_xfer;
  logic             ovr_set;
  logic [NP-1:0]    raw_pix;
  logic [NP-1:0]    out_word;

  // The output word is derived from the next shadow/pointer so it lands in the
  // same register stage as out_valid; scaling adds no cycle.
  assign raw_pix = pick_pixel(shadow_d, pixel_d);

`ifdef PEAK_DEPTH_SCALE_EN
  peak_depth_scaler #(
    .SCALE       (SCALE),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_scaler (
    .peak_i  (raw_pix),
    .depth_o (out_word)
  );
`else
  assign out_word = raw_pix;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    pixel_d       = pixel_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    frame_id_d    = frame_id_q;
    ovr_set       = 1'b0;

    xfer      = out_valid_q && out_if.out_ready;
    last_xfer = xfer && (pixel_q == PIX_W'(LAST_PIX));

    case (state_q)
      IDLE: begin
        if (peak_valid) begin
          shadow_d = peak_data;
          pixel_d  = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          frame_id_d = frame_id_q + 1'b1;
          pixel_d    = '0;
          if (pending_vld_q) begin
            shadow_d      = pending_q;
            pending_vld_d = peak_valid;
            if (peak_valid) pending_d = peak_data;
          end else if (peak_valid) begin
            shadow_d = peak_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) pixel_d = pixel_q + 1'b1;
          if (peak_valid) begin
            if (!pending_vld_q) begin
              pending_d     = peak_data;
              pending_vld_d = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d   = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    out_valid_d = (state_d == STREAM);
    out_pixel_d = out_valid_d ? pixel_d : '0;
    out_last_d  = out_valid_d && (pixel_d == PIX_W'(LAST_PIX));
    out_data_d  = out_valid_d ? out_word : '0;
    busy_d      = out_valid_d || pending_vld_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= IDLE;
      pixel_q       <= '0;
      pending_vld_q <= 1'b0;
      frame_id_q    <= '0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_pixel_q   <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixel_q       <= pixel_d;
      pending_vld_q <= pending_vld_d;
      frame_id_q    <= frame_id_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_pixel_q   <= out_pixel_d;
      out_last_q    <= out_last_d;
    end
  end

  // NOTE: the frame buffers carry no reset; their valid qualifiers (state_q,
  // pending_vld_q) are reset, so stale contents can never be presented.
  always_ff @(posedge clk) begin
    shadow_q  <= shadow_d;
    pending_q <= pending_d;
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_pixel = out_pixel_q;
  assign out_if.out_last  = out_last_q;
  assign frame_id         = frame_id_q;
  assign overrun          = overrun_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_peak_readout_streamer.sv
// Randomized + directed bench for peak_readout_streamer against a frame-queue model.
module tb_peak_readout_streamer;
  import peak_readout_streamer_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       peak_valid = 1'b0;
  frame_t     peak_data = '0;
  logic       overrun_clr = 1'b0;
  logic [7:0] frame_id;
  logic       overrun;
  logic       busy;

  peak_readout_streamer_if u_if ();

  peak_readout_streamer dut (
    .clk         (clk),
    .res         (res),
    .peak_valid  (peak_valid),
    .peak_data   (peak_data),
    .overrun_clr (overrun_clr),
    .out_if      (u_if.master),
    .frame_id    (frame_id),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frames awaiting or in transmission (front = streaming).
  frame_t fq[$];
  int     beat = 0;
  int     fid  = 0;
  bit     ovr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [15:0] v);
    int unsigned p;
`ifdef PEAK_DEPTH_SCALE_EN
    p = (32'(v) * 150) / 16;
    if (p > 32'hFFFF) p = 32'hFFFF;
`else
    p = 32'(v);
`endif
    return p;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < NP*PIXEL_NUM/32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic model_reset();
    fq.delete();
    beat = 0;
    fid  = 0;
    ovr  = 1'b0;
  endtask

  task automatic compare();
    bit ev;
    ev = (fq.size() > 0);
    check("valid", 32'(u_if.out_valid), 32'(ev));
    check("busy", 32'(busy), 32'(ev));
    check("overrun", 32'(overrun), 32'(ovr));
    check("frame_id", 32'(frame_id), 32'(fid));
    if (ev) begin
      check("data", 32'(u_if.out_data), exp_word(fq[0][beat*NP +: NP]));
      check("pixel", 32'(u_if.out_pixel), 32'(beat));
      check("last", 32'(u_if.out_last), 32'(beat == PIXEL_NUM-1));
    end else begin
      check("last_idle", 32'(u_if.out_last), 32'd0);
    end
  endtask

  task automatic step(input bit pv, input frame_t d, input bit rdy, input bit clr);
    bit drop;
    peak_valid     = pv;
    peak_data      = d;
    u_if.out_ready = rdy;
    overrun_clr    = clr;
    @(posedge clk);
    if (res) begin
      if (fq.size() > 0 && rdy) begin
        beat++;
        if (beat == PIXEL_NUM) begin
          void'(fq.pop_front());
          beat = 0;
          fid  = (fid + 1) % 256;
        end
      end
      drop = pv && (fq.size() >= 2);
      if (pv && !drop) fq.push_back(d);
      if (drop) ovr = 1'b1;
      else if (clr) ovr = 1'b0;
    end
    #1;
    compare();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(u_if.out_valid), 32'd0);
    check({tag, "_data"}, 32'(u_if.out_data), 32'd0);
    check({tag, "_pixel"}, 32'(u_if.out_pixel), 32'd0);
    check({tag, "_last"}, 32'(u_if.out_last), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fid"}, 32'(frame_id), 32'd0);
  endtask

  initial begin
    frame_t fa, fb;
    u_if.out_ready = 1'b0;
    #3;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    res = 1'b1;
    idle(2, 1'b1);

    // Basic stream 0x0010..0x0017.
    for (int k = 0; k < PIXEL_NUM; k++) fa[k*NP +: NP] = 16'(16 + k);
    step(1'b1, fa, 1'b1, 1'b0);
    idle(10, 1'b1);
    check("basic_fid", 32'(frame_id), 32'd1);

    // Backpressure 1,0,0,1 pattern.
    fa = rand_frame();
    step(1'b1, fa, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3), 1'b0);

    // Pending frame arriving at beat 3, no bubble.
    fa = rand_frame();
    fb = rand_frame();
    step(1'b1, fa, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b1, fb, 1'b1, 1'b0);
    idle(16, 1'b1);

    // Overrun: third frame dropped, then clear, then set+clear together.
    step(1'b1, rand_frame(), 1'b0, 1'b0);
    step(1'b1, rand_frame(), 1'b0, 1'b0);
    step(1'b1, rand_frame(), 1'b0, 1'b0);
    check("ovr_set", 32'(overrun), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, rand_frame(), 1'b0, 1'b1);
    check("ovr_set_wins", 32'(overrun), 32'd1);
    idle(20, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);

    // Reset mid-stream at beat 4.
    step(1'b1, rand_frame(), 1'b1, 1'b0);
    idle(4, 1'b1);
    res = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk); #1;
    res = 1'b1;
    idle(4, 1'b1);

`ifdef PEAK_DEPTH_SCALE_EN
    for (int k = 0; k < PIXEL_NUM; k++) fa[k*NP +: NP] = (k == 1) ? 16'hFFFF : 16'h0100;
    step(1'b1, fa, 1'b0, 1'b0);
    check("scale_0100", 32'(u_if.out_data), 32'h0960);
    step(1'b0, '0, 1'b1, 1'b0);
    check("scale_sat", 32'(u_if.out_data), 32'hFFFF);
    idle(10, 1'b1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(5) == 0, rand_frame(), $urandom_range(9) < 7, $urandom_range(19) == 0);
    idle(30, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
